// File: rtl/fetch_unit.sv
// Instruction fetch: drives the PC register, issues in-order imem requests and queues
// returned words toward decode. Optional FETCH_MISALIGN_CHECK_EN halts on misaligned redirects.
module fetch_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            if_misalign
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                      started_q;
    logic                      epoch_q, epoch_d;
    logic [DEPTH-1:0][XLEN-1:0] tag_pc_q;
    logic [DEPTH-1:0]          tag_ep_q, tag_live_q;
    logic [AW-1:0]             tag_wr_q, tag_rd_q;
    logic [CW-1:0]             inflight_q, inflight_d;
    logic [DEPTH-1:0][XLEN-1:0] fifo_pc_q, fifo_data_q;
    logic [AW-1:0]             f_wr_q, f_rd_q;
    logic [CW-1:0]             f_cnt_q, f_cnt_d;
    logic [CW-1:0]             occ;
    logic                      halted;
    logic                      redir, req_fire, rsp_keep, pop;
    logic [XLEN-1:0]           target_eff;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halted_q, halted_d;
    assign halted      = halted_q;
    assign if_misalign = halted_q;
    assign target_eff  = redirect_target;
    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) halted_d = (redirect_target[1:0] != 2'b00);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= halted_d;
    end
`else
    assign halted     = 1'b0;
    assign target_eff = redirect_target & ~XLEN'(3);
`endif

    // Credits cover both in-flight requests and buffered words, so the FIFO cannot overflow.
    assign occ            = inflight_q + f_cnt_q;
    assign imem_req_valid = started_q & (occ < CW'(DEPTH)) & ~redirect_valid & ~halted;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign redir          = redirect_valid & ~reset;
    assign pc_en          = redir | req_fire;
    assign pc_next        = redir ? target_eff : (req_fire ? pc + XLEN'(4) : '0);

    // Live bits kill every older tag on redirect, so an aliased one-bit epoch is harmless.
    assign rsp_keep = imem_rsp_valid & ~redirect_valid & tag_live_q[tag_rd_q]
                    & (tag_ep_q[tag_rd_q] == epoch_q);
    assign if_valid = (f_cnt_q != '0);
    assign if_instr = fifo_data_q[f_rd_q];
    assign if_pc    = fifo_pc_q[f_rd_q];
    assign pop      = if_valid & if_ready & ~redirect_valid;

    always_comb begin
        epoch_d    = epoch_q ^ redirect_valid;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        f_cnt_d    = redirect_valid ? '0 : f_cnt_q + CW'(rsp_keep) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q   <= 1'b0;
            epoch_q     <= 1'b0;
            inflight_q  <= '0;
            f_cnt_q     <= '0;
            tag_pc_q    <= '0;
            tag_ep_q    <= '0;
            tag_live_q  <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            fifo_pc_q   <= '0;
            fifo_data_q <= '0;
            f_wr_q      <= '0;
            f_rd_q      <= '0;
        end else begin
            started_q  <= 1'b1;
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
            f_cnt_q    <= f_cnt_d;
            if (redirect_valid) tag_live_q <= '0;
            if (req_fire) begin
                tag_pc_q[tag_wr_q]   <= pc;
                tag_ep_q[tag_wr_q]   <= epoch_q;
                tag_live_q[tag_wr_q] <= 1'b1;
                tag_wr_q             <= tag_wr_q + AW'(1);
            end
            if (imem_rsp_valid) tag_rd_q <= tag_rd_q + AW'(1);
            if (redirect_valid) begin
                f_wr_q <= '0;
                f_rd_q <= '0;
            end else begin
                if (rsp_keep) begin
                    fifo_pc_q[f_wr_q]   <= tag_pc_q[tag_rd_q];
                    fifo_data_q[f_wr_q] <= imem_rsp_data;
                    f_wr_q              <= f_wr_q + AW'(1);
                end
                if (pop) f_rd_q <= f_rd_q + AW'(1);
            end
        end
    end

    // A response with nothing outstanding means the memory broke the protocol.
    always_ff @(posedge clk) begin
        if (!reset && imem_rsp_valid) assert (inflight_q != '0);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model answers requests in order with random
// latency; a scoreboard queue holds the expected fetch stream and a monitor checks decode.
module tb_fetch_unit;
    logic        clk, reset;
    logic [31:0] pc;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        if_misalign;
`endif

    fetch_unit #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .pc_next(pc_next),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .if_misalign(if_misalign)
`endif
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit live; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mem_q[$];
    exp_t        sb_q[$];
    int          n_buf;
    logic [31:0] m_pc;
    bit          started, m_halt;
    int          total, bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register the unit drives
    always @(posedge clk or posedge reset) begin
        if (reset)      pc <= 32'h0;
        else if (pc_en) pc <= pc_next;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        #2;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_pc_next", pc_next, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_req_addr", imem_req_addr, pc);
        mem_q.delete();
        sb_q.delete();
        n_buf = 0;
        m_pc = 32'h0;
        m_halt = 1'b0;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b0;
        reset = 1'b0;
        started = 1'b0;
    endtask

    // Monitor: every accepted decode beat must match the oldest expected fetch.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset && if_valid && if_ready) begin
                if (sb_q.size() == 0) begin
                    chk("if_unexpected", if_valid, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                end
            end
        end
    end

    initial begin
        bit          redir, rdy, rsp_now, exp_rv, fire, pop_now;
        int          lat;
        logic [31:0] tgt, exp_tgt, d;
        total = 0; bad = 0;
        reset = 1'b1;
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            if (c == 900) do_reset();
            else if (c > 0) @(negedge clk);
            redir = 1'b0;
            tgt = 32'h0;
            if (c < 50) begin
                rdy = 1'b1; if_ready = 1'b1; lat = 0;
            end else if (c < 80) begin
                rdy = 1'b1; if_ready = 1'b0; lat = 0;
            end else begin
                rdy = ($urandom_range(0, 3) != 0) && !(c >= 300 && c < 340);
                if_ready = ($urandom_range(0, 2) != 0);
                lat = $urandom_range(0, 3);
                redir = ($urandom_range(0, 19) == 0);
                case ($urandom_range(0, 5))
                    0: tgt = 32'hFFFF_FFF8;
                    1: tgt = 32'h0000_0102;
                    2: tgt = 32'h0000_0100;
                    3: tgt = $urandom;
                    default: tgt = $urandom & 32'hFFFF_FFFC;
                endcase
            end
            redirect_valid = redir;
            redirect_target = tgt;
            imem_req_ready = rdy;
            rsp_now = (mem_q.size() > 0) && (mem_q[0].due <= c);
            imem_rsp_valid = rsp_now;
            imem_rsp_data = rsp_now ? mem_q[0].data : $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            exp_tgt = tgt;
`else
            exp_tgt = {tgt[31:2], 2'b00};
`endif
            #2;
            exp_rv = started && (mem_q.size() + n_buf < 4) && !redir && !m_halt;
            fire = exp_rv && rdy;
            chk("pc_reg", pc, m_pc);
            chk("req_valid", imem_req_valid, exp_rv);
            chk("if_valid", if_valid, n_buf > 0);
            chk("pc_en", pc_en, redir || fire);
            if (redir) chk("pc_next_redirect", pc_next, exp_tgt);
            else if (fire) chk("pc_next_inc", pc_next, m_pc + 32'd4);
            if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("if_misalign", if_misalign, m_halt);
`endif
            pop_now = (n_buf > 0) && if_ready;
            if (rsp_now) begin
                mreq_t m;
                m = mem_q.pop_front();
                if (m.live && !redir) n_buf++;
            end
            if (pop_now) n_buf--;
            if (redir) begin
                n_buf = 0;
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
                sb_q.delete();
                m_pc = exp_tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
                m_halt = (tgt[1:0] != 2'b00);
`endif
            end else if (fire) begin
                d = $urandom;
                mem_q.push_back('{addr: m_pc, data: d, due: c + 1 + lat, live: 1'b1});
                sb_q.push_back('{pc: m_pc, instr: d});
                m_pc = m_pc + 32'd4;
            end
            started = 1'b1;
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
